// File: rtl/uart_rx_pkg.sv
// Purpose: shared constants and helpers for the UART receive datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: parity-mode codes, receive FIFO entry layout, data-length clamp.
package uart_rx_pkg;

    // Parity mode codes as seen on cfg_par
    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    localparam int MIN_DATA_W = 5;

    // Entry layout: data in [max_data_w-1:0], then perr, ferr, brk above it.
    function automatic int ent_w(input int max_data_w);
        return max_data_w + 3;
    endfunction

    function automatic int ent_perr_bit(input int max_data_w);
        return max_data_w;
    endfunction

    function automatic int ent_ferr_bit(input int max_data_w);
        return max_data_w + 1;
    endfunction

    function automatic int ent_brk_bit(input int max_data_w);
        return max_data_w + 2;
    endfunction

    // Out-of-range lengths fall back to the widest supported frame.
    function automatic logic [3:0] eff_len(input logic [3:0] len, input int max_data_w);
        if (int'(len) >= MIN_DATA_W && int'(len) <= max_data_w) begin
            return len;
        end
        return 4'(max_data_w);
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Purpose: generic synchronous first-word-fall-through FIFO (shared with the TX path).
// Latency: push visible on rd_dat one cycle later; pop advances head one cycle later.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty ignored.
// Ports: clk, rst (sync, active-high), push/push_dat, pop, flush -> rd_dat (0 when empty), full, empty, count.
module rx_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

    // A pop frees the slot the simultaneous push needs when full.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign rd_dat = empty ? '0 : mem_q[rd_ptr_q];
    assign count  = cnt_q;

endmodule

// File: rtl/uart_rx_datapath_fifo.sv
// Purpose: UART receive datapath - shift register, per-frame parity/framing/break checks, receive FIFO.
// Latency: DONE in cycle t makes the checked entry visible on rd_* / RXRDY at t+1.
// Backpressure: frames arriving while the FIFO is full (no pop) are dropped and flagged on sticky OVF.
// Ports: clk, rst, BTU/START/RX/DONE from the RX control FSM; cfg_* frame format;
//        pop/flush/clr from the CPU side; rd_* head entry, RXRDY, full, count, OVF.
module uart_rx_datapath_fifo
    import uart_rx_pkg::*;
#(
    parameter int MAX_DATA_W = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  BTU,
    input  logic                  START,
    input  logic                  RX,
    input  logic                  DONE,
    input  logic [3:0]            cfg_len,
    input  logic                  cfg_pen,
    input  logic [1:0]            cfg_par,
    input  logic                  cfg_stop2,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  clr,
    output logic [MAX_DATA_W-1:0] rd_data,
    output logic                  rd_perr,
    output logic                  rd_ferr,
    output logic                  rd_brk,
    output logic                  RXRDY,
    output logic                  full,
    output logic [CNT_W-1:0]      count,
    output logic                  OVF
);

    localparam int SR_W     = MAX_DATA_W + 3;
    localparam int ENT_W    = ent_w(MAX_DATA_W);
    localparam int PERR_BIT = ent_perr_bit(MAX_DATA_W);
    localparam int FERR_BIT = ent_ferr_bit(MAX_DATA_W);
    localparam int BRK_BIT  = ent_brk_bit(MAX_DATA_W);

    logic [SR_W-1:0]       sr_q, sr_d;
    logic                  ovf_q, ovf_d;

    logic [3:0]            len_eff;
    logic [3:0]            frame_n;
    logic [3:0]            stop_a_idx;
    logic [SR_W-1:0]       frame;
    logic [MAX_DATA_W-1:0] data;
    logic                  par_bit, exp_par, stop_a, stop_b, any_one;
    logic                  perr, ferr, brk;

    logic [ENT_W-1:0]      push_ent, rd_ent;
    logic                  fifo_full, fifo_empty;

    // New bits enter at the MSB, so the last N received bits sit in the top N positions.
    assign sr_d = (BTU & ~START) ? {RX, sr_q[SR_W-1:1]} : sr_q;

    always_comb begin
        len_eff    = eff_len(cfg_len, MAX_DATA_W);
        frame_n    = len_eff + {3'b000, cfg_pen} + 4'd1 + {3'b000, cfg_stop2};
        stop_a_idx = len_eff + {3'b000, cfg_pen};
        // Right-align the frame so the first-received bit lands at bit 0.
        frame      = sr_q >> (4'(SR_W) - frame_n);

        data = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < int'(len_eff)) data[i] = frame[i];
        end

        // Variable-position bit picks done by loop to keep index widths independent of SR_W.
        par_bit = 1'b0;
        stop_a  = 1'b0;
        stop_b  = 1'b0;
        any_one = 1'b0;
        for (int i = 0; i < SR_W; i++) begin
            if (i == int'(len_eff))        par_bit = frame[i];
            if (i == int'(stop_a_idx))     stop_a  = frame[i];
            if (i == int'(stop_a_idx) + 1) stop_b  = frame[i];
            if (i < int'(frame_n))         any_one = any_one | frame[i];
        end

        case (cfg_par)
            PAR_EVEN:  exp_par = ^data;
            PAR_ODD:   exp_par = ~^data;
            PAR_MARK:  exp_par = 1'b1;
            PAR_SPACE: exp_par = 1'b0;
            default:   exp_par = 1'b0;
        endcase

        perr = cfg_pen & (par_bit != exp_par);
        brk  = ~any_one;
        ferr = ~stop_a | (cfg_stop2 & ~stop_b) | brk;
    end

    assign push_ent = {brk, ferr, perr, data};

    rx_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (DONE),
        .push_dat (push_ent),
        .pop      (pop),
        .flush    (flush),
        .rd_dat   (rd_ent),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    // Drop is only a loss when no pop makes room and no flush discards the frame anyway.
    always_comb begin
        ovf_d = ovf_q;
        if (clr) ovf_d = 1'b0;
        if (DONE & fifo_full & ~pop & ~flush) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            ovf_q <= ovf_d;
        end
    end

    assign rd_data = rd_ent[MAX_DATA_W-1:0];
    assign rd_perr = rd_ent[PERR_BIT];
    assign rd_ferr = rd_ent[FERR_BIT];
    assign rd_brk  = rd_ent[BRK_BIT];
    assign RXRDY   = ~fifo_empty;
    assign full    = fifo_full;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_uart_rx_datapath_fifo.sv
// Purpose: self-checking bench for uart_rx_datapath_fifo (directed frames plus randomized frames vs a reference model).
// Latency: inputs driven 1 time unit after each rising edge; outputs sampled at that same point.
// Backpressure: FIFO full/overflow, simultaneous push/pop, flush and mid-frame reset scenarios.
module tb_uart_rx_datapath_fifo;

    logic       clk = 1'b0;
    logic       rst, BTU, START, RX, DONE;
    logic [3:0] cfg_len;
    logic       cfg_pen;
    logic [1:0] cfg_par;
    logic       cfg_stop2;
    logic       pop, flush, clr;
    logic [7:0] rd_data;
    logic       rd_perr, rd_ferr, rd_brk, RXRDY, full, OVF;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    logic [10:0] mq[$];

    uart_rx_datapath_fifo #(.MAX_DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .BTU(BTU), .START(START), .RX(RX), .DONE(DONE),
        .cfg_len(cfg_len), .cfg_pen(cfg_pen), .cfg_par(cfg_par), .cfg_stop2(cfg_stop2),
        .pop(pop), .flush(flush), .clr(clr),
        .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr), .rd_brk(rd_brk),
        .RXRDY(RXRDY), .full(full), .count(count), .OVF(OVF)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [3:0] len, input logic pen, input logic [1:0] par, input logic st2);
        cfg_len = len; cfg_pen = pen; cfg_par = par; cfg_stop2 = st2;
    endtask

    // Start bit (BTU with START high, must not shift) followed by n serial bits, LSB first.
    task automatic send_frame(input logic [11:0] bits, input int n);
        START = 1'b1; BTU = 1'b1; RX = 1'b0;
        tick();
        START = 1'b0;
        for (int i = 0; i < n; i++) begin
            RX = bits[i]; BTU = 1'b1;
            tick();
        end
        BTU = 1'b0; RX = 1'b1;
    endtask

    task automatic pulse_done(input logic with_pop, input logic with_shift);
        DONE = 1'b1; pop = with_pop;
        if (with_shift) begin BTU = 1'b1; RX = 1'($urandom); end
        tick();
        DONE = 1'b0; pop = 1'b0; BTU = 1'b0; RX = 1'b1;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    function automatic int eff(input logic [3:0] len);
        return (len >= 4'd5 && len <= 4'd8) ? int'(len) : 8;
    endfunction

    function automatic logic [11:0] build(input logic [8:0] d, input int L, input bit pen,
                                          input bit pb, input bit s1, input bit s2);
        logic [11:0] b;
        int p;
        b = '0;
        for (int i = 0; i < L; i++) b[i] = d[i];
        p = L;
        if (pen) begin b[p] = pb; p++; end
        b[p] = s1;
        b[p+1] = s2;
        return b;
    endfunction

    // Expected FIFO entry {brk, ferr, perr, data} computed from the transmitted bit list.
    function automatic logic [10:0] model_entry(input logic [11:0] b, input int L, input bit pen,
                                                input logic [1:0] par, input bit st2);
        int n;
        logic [7:0] d;
        bit ep, perr, ferr, brk;
        n = L + int'(pen) + 1 + int'(st2);
        d = '0;
        for (int i = 0; i < L; i++) d[i] = b[i];
        case (par)
            2'd0:    ep = ^d;
            2'd1:    ep = ~^d;
            2'd2:    ep = 1'b1;
            default: ep = 1'b0;
        endcase
        perr = pen && (b[L] != ep);
        ferr = (b[L + int'(pen)] == 1'b0) || (st2 && b[L + int'(pen) + 1] == 1'b0);
        brk  = 1'b1;
        for (int i = 0; i < n; i++) if (b[i]) brk = 1'b0;
        if (brk) ferr = 1'b1;
        return {brk, ferr, perr, d};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (RXRDY !== 1'b0) begin bad++; $display("FAIL reset_rxrdy: got %b want 0", RXRDY); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
        total++; if (OVF !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", OVF); end
        total++; if ({rd_brk, rd_ferr, rd_perr, rd_data} !== 11'h000) begin
            bad++; $display("FAIL reset_rd: got %h want 000", {rd_brk, rd_ferr, rd_perr, rd_data}); end
    endtask

    task automatic test_8n1();
        set_cfg(4'd8, 1'b0, 2'd0, 1'b0);
        send_frame(build(9'h0A5, 8, 0, 0, 1, 0), 9);
        total++; if (RXRDY !== 1'b0) begin bad++; $display("FAIL 8n1_pre_done: got %b want 0", RXRDY); end
        pulse_done(1'b0, 1'b0);
        total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL 8n1_data: got %h want a5", rd_data); end
        total++; if ({rd_brk, rd_ferr, rd_perr} !== 3'b000) begin
            bad++; $display("FAIL 8n1_flags: got %b want 000", {rd_brk, rd_ferr, rd_perr}); end
        total++; if (RXRDY !== 1'b1) begin bad++; $display("FAIL 8n1_rxrdy: got %b want 1", RXRDY); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL 8n1_count: got %0d want 1", count); end
        do_pop();
        total++; if (RXRDY !== 1'b0) begin bad++; $display("FAIL 8n1_pop_empty: got %b want 0", RXRDY); end
    endtask

    task automatic test_parity();
        set_cfg(4'd7, 1'b1, 2'd0, 1'b0);
        send_frame(build(9'h041, 7, 1, 1, 1, 0), 9);
        pulse_done(1'b0, 1'b0);
        total++; if (rd_data !== 8'h41) begin bad++; $display("FAIL 7e1_data: got %h want 41", rd_data); end
        total++; if (rd_perr !== 1'b1) begin bad++; $display("FAIL 7e1_bad_par: got %b want 1", rd_perr); end
        do_pop();
        send_frame(build(9'h041, 7, 1, 0, 1, 0), 9);
        pulse_done(1'b0, 1'b0);
        total++; if (rd_perr !== 1'b0) begin bad++; $display("FAIL 7e1_good_par: got %b want 0", rd_perr); end
        do_pop();
        set_cfg(4'd7, 1'b1, 2'd2, 1'b0);
        send_frame(build(9'h041, 7, 1, 0, 1, 0), 9);
        pulse_done(1'b0, 1'b0);
        total++; if (rd_perr !== 1'b1) begin bad++; $display("FAIL mark_par: got %b want 1", rd_perr); end
        do_pop();
    endtask

    task automatic test_framing();
        set_cfg(4'd8, 1'b1, 2'd1, 1'b1);
        send_frame(build(9'h03C, 8, 1, 1, 1, 0), 11);
        pulse_done(1'b0, 1'b0);
        total++; if ({rd_brk, rd_ferr, rd_perr, rd_data} !== {3'b010, 8'h3C}) begin
            bad++; $display("FAIL 8o2_stop: got %h want 23c", {rd_brk, rd_ferr, rd_perr, rd_data}); end
        do_pop();
        set_cfg(4'd8, 1'b0, 2'd0, 1'b0);
        send_frame(12'h000, 9);
        pulse_done(1'b0, 1'b0);
        total++; if ({rd_brk, rd_ferr, rd_perr, rd_data} !== {3'b110, 8'h00}) begin
            bad++; $display("FAIL break: got %h want 600", {rd_brk, rd_ferr, rd_perr, rd_data}); end
        do_pop();
    endtask

    task automatic test_random_frames();
        logic [3:0]  len;
        logic [1:0]  par;
        logic [11:0] bits;
        bit          pen, st2;
        int          L, n;
        mq.delete();
        for (int it = 0; it < 60; it++) begin
            if (mq.size() == 4 || (mq.size() > 0 && $urandom_range(0, 2) == 0)) begin
                total++; if ({rd_brk, rd_ferr, rd_perr, rd_data} !== mq[0]) begin
                    bad++; $display("FAIL rand_head_pop it=%0d: got %h want %h", it,
                                    {rd_brk, rd_ferr, rd_perr, rd_data}, mq[0]); end
                do_pop();
                void'(mq.pop_front());
            end
            len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 8));
            pen = 1'($urandom);
            par = 2'($urandom);
            st2 = 1'($urandom);
            set_cfg(len, pen, par, st2);
            L = eff(len);
            n = L + int'(pen) + 1 + int'(st2);
            if ($urandom_range(0, 7) == 0) bits = '0;
            else bits = build(9'($urandom), L, pen, 1'($urandom),
                              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            send_frame(bits, n);
            pulse_done(1'b0, 1'($urandom));
            mq.push_back(model_entry(bits, L, pen, par, st2));
            total++; if (count !== 3'(mq.size())) begin
                bad++; $display("FAIL rand_count it=%0d: got %0d want %0d", it, count, mq.size()); end
            total++; if ({rd_brk, rd_ferr, rd_perr, rd_data} !== mq[0]) begin
                bad++; $display("FAIL rand_head it=%0d: got %h want %h", it,
                                {rd_brk, rd_ferr, rd_perr, rd_data}, mq[0]); end
        end
        while (mq.size() > 0) begin
            total++; if ({rd_brk, rd_ferr, rd_perr, rd_data} !== mq[0]) begin
                bad++; $display("FAIL rand_drain: got %h want %h", {rd_brk, rd_ferr, rd_perr, rd_data}, mq[0]); end
            do_pop();
            void'(mq.pop_front());
        end
        total++; if (RXRDY !== 1'b0) begin bad++; $display("FAIL rand_drain_empty: got %b want 0", RXRDY); end
    endtask

    task automatic test_overflow();
        set_cfg(4'd8, 1'b0, 2'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            send_frame(build(9'(17 * k), 8, 0, 0, 1, 0), 9);
            pulse_done(1'b0, 1'b0);
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", full); end
        total++; if (OVF !== 1'b0) begin bad++; $display("FAIL ovf_pre: got %b want 0", OVF); end
        send_frame(build(9'h055, 8, 0, 0, 1, 0), 9);
        pulse_done(1'b0, 1'b0);
        total++; if (OVF !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", OVF); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", count); end
        for (int k = 1; k <= 4; k++) begin
            total++; if (rd_data !== 8'(17 * k)) begin
                bad++; $display("FAIL ovf_order k=%0d: got %h want %h", k, rd_data, 8'(17 * k)); end
            do_pop();
        end
        total++; if (RXRDY !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %b want 0", RXRDY); end
        clr = 1'b1; tick(); clr = 1'b0;
        total++; if (OVF !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", OVF); end
    endtask

    task automatic test_full_cases();
        logic [7:0] exp_d [4];
        set_cfg(4'd8, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send_frame(build(9'(17 * (k + 1)), 8, 0, 0, 1, 0), 9);
            pulse_done(1'b0, 1'b0);
        end
        send_frame(build(9'h066, 8, 0, 0, 1, 0), 9);
        pulse_done(1'b1, 1'b0);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fullpop_count: got %0d want 4", count); end
        total++; if (OVF !== 1'b0) begin bad++; $display("FAIL fullpop_ovf: got %b want 0", OVF); end
        exp_d[0] = 8'h22; exp_d[1] = 8'h33; exp_d[2] = 8'h44; exp_d[3] = 8'h66;
        for (int k = 0; k < 4; k++) begin
            total++; if (rd_data !== exp_d[k]) begin
                bad++; $display("FAIL fullpop_order k=%0d: got %h want %h", k, rd_data, exp_d[k]); end
            do_pop();
        end
        // Fill again, then an overflow coinciding with clr: the set must win.
        for (int k = 0; k < 4; k++) begin
            send_frame(build(9'($urandom), 8, 0, 0, 1, 0), 9);
            pulse_done(1'b0, 1'b0);
        end
        send_frame(build(9'h077, 8, 0, 0, 1, 0), 9);
        clr = 1'b1;
        pulse_done(1'b0, 1'b0);
        clr = 1'b0;
        total++; if (OVF !== 1'b1) begin bad++; $display("FAIL ovf_set_over_clr: got %b want 1", OVF); end
        clr = 1'b1; tick(); clr = 1'b0;
        // Flush with a DONE in the same cycle discards everything without flagging overflow.
        send_frame(build(9'h088, 8, 0, 0, 1, 0), 9);
        flush = 1'b1;
        pulse_done(1'b0, 1'b0);
        flush = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count); end
        total++; if (OVF !== 1'b0) begin bad++; $display("FAIL flush_ovf: got %b want 0", OVF); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL flush_rd: got %h want 00", rd_data); end
    endtask

    task automatic test_empty_done_pop();
        set_cfg(4'd8, 1'b0, 2'd0, 1'b0);
        send_frame(build(9'h05A, 8, 0, 0, 1, 0), 9);
        pulse_done(1'b1, 1'b0);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL emptypop_count: got %0d want 1", count); end
        total++; if (rd_data !== 8'h5A) begin bad++; $display("FAIL emptypop_data: got %h want 5a", rd_data); end
        do_pop();
    endtask

    task automatic test_mid_reset();
        set_cfg(4'd8, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            send_frame(build(9'($urandom), 8, 0, 0, 1, 0), 9);
            pulse_done(1'b0, 1'b0);
        end
        send_frame(12'hFFF, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", count); end
        total++; if (RXRDY !== 1'b0) begin bad++; $display("FAIL midrst_rxrdy: got %b want 0", RXRDY); end
        total++; if (OVF !== 1'b0) begin bad++; $display("FAIL midrst_ovf: got %b want 0", OVF); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL midrst_rd: got %h want 00", rd_data); end
        send_frame(build(9'h0C3, 8, 0, 0, 1, 0), 9);
        pulse_done(1'b0, 1'b0);
        total++; if ({rd_brk, rd_ferr, rd_perr, rd_data} !== {3'b000, 8'hC3}) begin
            bad++; $display("FAIL midrst_next: got %h want 0c3", {rd_brk, rd_ferr, rd_perr, rd_data}); end
        do_pop();
    endtask

    initial begin
        rst = 1'b1; BTU = 1'b0; START = 1'b0; RX = 1'b1; DONE = 1'b0;
        pop = 1'b0; flush = 1'b0; clr = 1'b0;
        set_cfg(4'd8, 1'b0, 2'd0, 1'b0);
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_random_frames();
        test_overflow();
        test_full_cases();
        test_empty_done_pop();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
